uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing one UART transmitter (range 2..8).
REQ-002 SHALL have parameter DATA_W, default 8: byte width.
REQ-003 SHALL have port clk_i, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port req_i, input, N_REQ: per-requester level request.
REQ-006 SHALL have port data_i, input, N_REQ*DATA_W: requester k byte at [k*DATA_W +: DATA_W].
REQ-007 SHALL have port lock_i, input, N_REQ: per-requester grant-hold request; used only with UART_ARB_LOCK_EN.
REQ-008 SHALL have port ack_o, output, N_REQ: one-cycle pulse, byte of requester k captured.
REQ-009 SHALL have port grant_o, output, N_REQ: one-hot owner of the current transfer, zero when idle.
REQ-010 SHALL have port tx_start_o, output, 1: one-cycle start strobe to the UART transmitter.
REQ-011 SHALL have port tx_data_o, output, DATA_W: byte to transmit, held stable from the start strobe until the next grant.
REQ-012 SHALL have port tx_busy_i, input, 1: transmitter busy, high while shifting a frame.
REQ-013 SHALL have port busy_o, output, 1: arbiter not in IDLE.

Function
REQ-014 SHALL implement states IDLE, WAIT_BUSY and WAIT_DONE.
REQ-015 In IDLE with any eligible req_i bit and tx_busy_i=0, at the next edge the block SHALL perform all of the following: register the winner into grant_o; set tx_start_o=1 and the winner's ack_o bit; load tx_data_o from the winner's data_i; enter WAIT_BUSY.
REQ-016 tx_start_o and ack_o SHALL be high for exactly one cycle, which is the cycle after the request is sampled.
REQ-017 In IDLE with tx_busy_i=1, the block SHALL grant nothing and remain in IDLE.
REQ-018 WAIT_BUSY SHALL move to WAIT_DONE on tx_busy_i=1; WAIT_DONE SHALL move to IDLE on tx_busy_i=0 and clear grant_o.
REQ-019 Arbitration SHALL be round-robin: the search starts at (last_grant+1) mod N_REQ, and last_grant updates only on an actual grant.
REQ-020 Requesters SHALL hold req_i and data_i until ack_o; req_i changes in any non-IDLE state SHALL have no effect.
REQ-021 Throughput: a requester holding req_i continuously SHALL be re-arbitrated in the first IDLE cycle; the minimum gap is one IDLE cycle between frames.
REQ-022 Simultaneous requests SHALL yield exactly one grant per frame; a grant SHALL never go to a requester whose req_i is low.

Reset
REQ-023 rst_n_i low SHALL asynchronously force all of the following: state to IDLE; ack_o, grant_o, tx_start_o, tx_data_o and busy_o to 0; last_grant to N_REQ-1, so requester 0 wins first.
REQ-024 Reset mid-transfer SHALL abandon the transfer; no ack_o or tx_start_o SHALL be produced by the aborted transfer.
REQ-025 Deassertion of rst_n_i SHALL be used synchronously, so the first grant occurs no earlier than the second rising edge after release.

Configuration
REQ-026 Macro UART_ARB_LOCK_EN defined: if lock_i[g] of the last grantee is high in IDLE, only requester g is eligible; others wait until lock_i[g] falls, and the arbiter idles if req_i[g] is low.
REQ-027 Macro UART_ARB_LOCK_EN undefined: lock_i SHALL be ignored and pure round-robin SHALL apply; the port list SHALL be identical in both builds.

Structure
REQ-028 The shared package uart_pkg SHALL hold the state encoding, DATA_W default and N_REQ default.
REQ-029 A sub-module rr_arbiter SHALL provide a combinational rotating-priority one-hot select, taking req, last_grant and eligibility mask as inputs.

Verification
REQ-030 After reset, set req_i=4'b1111 with data 0x41/0x42/0x43/0x44 and a transmitter model with busy high for 10 cycles -> tx_data_o sequence 0x41,0x42,0x43,0x44,0x41, with one ack per frame in order 0,1,2,3,0.
REQ-031 Pulse req_i[2] alone (data 0x5A) from IDLE -> tx_start_o and ack_o[2] high together in the next cycle only, tx_data_o=0x5A, grant_o=4'b0100 until busy falls.
REQ-032 Hold tx_busy_i=1 externally with req_i[0]=1 -> no tx_start_o and no ack for the whole hold; then drop busy -> grant within one cycle.
REQ-033 Assert rst_n_i=0 during WAIT_DONE -> all outputs 0 immediately; after release, req_i=4'b1000 -> grant_o=4'b1000 with no stale ack.
REQ-034 With UART_ARB_LOCK_EN: grant requester 1 with lock_i[1]=1 and req_i=4'b1011 -> three consecutive frames go to requester 1; on lock_i[1]=0 the next grant goes to requester 3.
REQ-035 Without UART_ARB_LOCK_EN: same stimulus as REQ-034 -> grant order 1,3,0.

Source files
------------

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter:
//   - N_REQ_DEF / DATA_W_DEF : default requester count and byte width
//   - arb_state_e            : arbiter FSM state encoding
//   - idx_w()                : width of a requester index for a given count
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_e;

  // Requester index width; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational rotating-priority one-hot select. The search starts at
// (last_grant_i + 1) mod N_REQ and picks the first requester whose req_i and
// mask_i bits are both set.
// Ports:
//   req_i        [N_REQ]  request vector
//   last_grant_i [IDX_W]  index of the previous winner
//   mask_i       [N_REQ]  eligibility mask (1 = may win)
//   gnt_o        [N_REQ]  one-hot winner, zero when nobody is eligible
//   gnt_idx_o    [IDX_W]  index of the winner (0 when none)
//   valid_o               a winner exists
// ----------------------------------------------------------------------------
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  input  logic [N_REQ-1:0] mask_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             valid_o
);

  logic [N_REQ-1:0] elig;
  logic             found;

  assign elig = req_i & mask_i;

  // Outer loop walks priority offsets 1..N_REQ; the inner loop keeps every
  // vector index constant so the select maps onto plain muxes.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!found && elig[j] && (j == ((int'(last_grant_i) + i) % N_REQ))) begin
          gnt_o[j]  = 1'b1;
          gnt_idx_o = IDX_W'(j);
          found     = 1'b1;
        end
      end
    end
  end

  assign valid_o = found;

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between N_REQ requesters with round-robin
// arbitration.
//
// Handshakes:
//   requester -> arbiter : req_i[k] is a level; requester k holds req_i[k]
//                          and its data_i slice until ack_o[k] pulses. The
//                          byte is captured on the edge that raises ack_o.
//   arbiter -> UART      : tx_start_o pulses one cycle with tx_data_o valid;
//                          the UART answers by raising tx_busy_i for the
//                          frame and dropping it when done. tx_data_o stays
//                          put until the next grant.
//
// Optional feature (macro UART_ARB_LOCK_EN): while lock_i of the last
// grantee is high, only that requester may win. Without the macro lock_i is
// ignored. The port list is the same in both builds.
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   req_i      [N_REQ]    per-requester request level
//   data_i     [N_REQ*DW] requester k byte at [k*DATA_W +: DATA_W]
//   lock_i     [N_REQ]    per-requester grant-hold request
//   ack_o      [N_REQ]    one-cycle capture pulse
//   grant_o    [N_REQ]    one-hot owner of current transfer, zero when idle
//   tx_start_o            one-cycle start strobe to the UART
//   tx_data_o  [DATA_W]   byte to transmit
//   tx_busy_i             UART busy shifting a frame
//   busy_o                arbiter not in IDLE
// ----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*DATA_W-1:0] data_i,
  input  logic [N_REQ-1:0]        lock_i,
  output logic [N_REQ-1:0]        ack_o,
  output logic [N_REQ-1:0]        grant_o,
  output logic                    tx_start_o,
  output logic [DATA_W-1:0]       tx_data_o,
  input  logic                    tx_busy_i,
  output logic                    busy_o
);

  localparam int               IDX_W    = idx_w(N_REQ);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  arb_state_e        state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [IDX_W-1:0]  last_q, last_d;
  // Goes high on the first edge after reset release; arbitration is held
  // off until then so reset deassertion is only ever seen synchronously.
  logic              run_q;

  logic [N_REQ-1:0]  mask;
  logic [N_REQ-1:0]  win;
  logic [IDX_W-1:0]  win_idx;
  logic              win_vld;
  logic [DATA_W-1:0] win_data;

`ifdef UART_ARB_LOCK_EN
  // had_q distinguishes a real previous grantee from the reset value of
  // last_q, so a lock request cannot pin the arbiter before any grant.
  logic had_q, had_d;
  logic locked;

  always_comb begin
    locked = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (j == int'(last_q)) locked = had_q & lock_i[j];
    end
    for (int j = 0; j < N_REQ; j++) begin
      mask[j] = !locked || (j == int'(last_q));
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) had_q <= 1'b0;
    else          had_q <= had_d;
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock_i;
  assign mask        = '1;
`endif

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i        (req_i),
    .last_grant_i (last_q),
    .mask_i       (mask),
    .gnt_o        (win),
    .gnt_idx_o    (win_idx),
    .valid_o      (win_vld)
  );

  always_comb begin
    win_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win[k]) win_data = data_i[k*DATA_W +: DATA_W];
    end
  end

  // Next-state and registered-output logic. ack/tx_start default low so
  // they are single-cycle pulses by construction.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ack_d      = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    last_d     = last_q;
`ifdef UART_ARB_LOCK_EN
    had_d      = had_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (run_q && !tx_busy_i && win_vld) begin
          state_d    = ST_WAIT_BUSY;
          grant_d    = win;
          ack_d      = win;
          tx_start_d = 1'b1;
          tx_data_d  = win_data;
          last_d     = win_idx;
`ifdef UART_ARB_LOCK_EN
          had_d      = 1'b1;
`endif
        end
      end
      ST_WAIT_BUSY: begin
        if (tx_busy_i) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!tx_busy_i) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      last_q     <= LAST_RST;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      last_q     <= last_d;
      run_q      <= 1'b1;
    end
  end

  assign ack_o      = ack_q;
  assign grant_o    = grant_q;
  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Requesters are modelled as byte queues that hold req/data until acked; a
// transmitter model answers each start strobe with a busy pulse. Expected
// frames (requester, byte) come from a round-robin planner over the loaded
// queues and are popped by an independent monitor on every tx_start_o.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int EXP_W = 3 + DW;
  localparam int DEPTH = 8;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst_n_i;
  logic [N-1:0]    req_i;
  logic [N*DW-1:0] data_i;
  logic [N-1:0]    lock_i;
  logic [N-1:0]    ack_o;
  logic [N-1:0]    grant_o;
  logic            tx_start_o;
  logic [DW-1:0]   tx_data_o;
  logic            tx_busy_i;
  logic            busy_o;

  always #5 clk = ~clk;

  uart_tx_arbiter dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n_i),
    .req_i      (req_i),
    .data_i     (data_i),
    .lock_i     (lock_i),
    .ack_o      (ack_o),
    .grant_o    (grant_o),
    .tx_start_o (tx_start_o),
    .tx_data_o  (tx_data_o),
    .tx_busy_i  (tx_busy_i),
    .busy_o     (busy_o)
  );

  // ---------------- bench state ----------------
  logic [DW-1:0]    pend [N][DEPTH];
  int               head [N];
  int               cnt  [N];
  logic [N-1:0]     lock_hold;
  logic [EXP_W-1:0] exp_q [$];
  int               checks   = 0;
  int               failures = 0;
  int               mdl_last;

  logic tx_auto, force_busy, mdl_busy, tx_pending, tx_fixed;
  int   tx_wait, tx_left;
  assign tx_busy_i = tx_auto ? mdl_busy : force_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_reqs();
    for (int k = 0; k < N; k++) begin
      req_i[k]             = (cnt[k] > 0);
      data_i[k*DW +: DW]   = (cnt[k] > 0) ? pend[k][head[k]] : DW'($urandom);
      lock_i[k]            = lock_hold[k] && (cnt[k] > 0);
    end
  endtask

  task automatic push_byte(input int k, input logic [DW-1:0] b);
    pend[k][(head[k] + cnt[k]) % DEPTH] = b;
    cnt[k]++;
  endtask

  // One clock of requester and transmitter behaviour, at the falling edge.
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (ack_o[k] && cnt[k] > 0) begin
        head[k] = (head[k] + 1) % DEPTH;
        cnt[k]--;
      end
    end
    if (tx_auto) begin
      if (tx_start_o) begin
        tx_pending = 1'b1;
        tx_wait    = tx_fixed ? 0 : $urandom_range(0, 2);
      end
      if (tx_pending) begin
        if (tx_wait == 0) begin
          tx_pending = 1'b0;
          mdl_busy   = 1'b1;
          tx_left    = tx_fixed ? 10 : $urandom_range(1, 10);
        end else begin
          tx_wait--;
        end
      end else if (mdl_busy) begin
        tx_left--;
        if (tx_left == 0) mdl_busy = 1'b0;
      end
    end
    drive_reqs();
  endtask

  function automatic int pending_total();
    int t = 0;
    for (int k = 0; k < N; k++) t += cnt[k];
    return t;
  endfunction

  // Round-robin reference: serve the loaded queues one byte per frame,
  // searching from the requester after the previous winner.
  task automatic model_plan();
    int c[N];
    int h[N];
    int total;
    int k;
    total = 0;
    for (int i = 0; i < N; i++) begin
      c[i] = cnt[i];
      h[i] = head[i];
      total += c[i];
    end
    while (total > 0) begin
      for (int i = 1; i <= N; i++) begin
        k = (mdl_last + i) % N;
        if (c[k] > 0) begin
          exp_q.push_back({3'(k), pend[k][h[k]]});
          h[k] = (h[k] + 1) % DEPTH;
          c[k]--;
          total--;
          mdl_last = k;
          break;
        end
      end
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || busy_o || tx_busy_i || pending_total() > 0) && n < 3000) begin
      tick();
      n++;
    end
    chk({name, "_drain_in_budget"}, 32'(n < 3000), 32'd1);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [EXP_W-1:0] mon_e;
  logic [DW-1:0]    held_data = '0;
  logic [N-1:0]     oh;

  always @(negedge clk) begin
    if (rst_n_i === 1'b1) begin
      if (tx_start_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_start", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          oh    = N'(1) << mon_e[EXP_W-1:DW];
          chk("frame_data", 32'(tx_data_o), 32'(mon_e[DW-1:0]));
          chk("frame_grant", 32'(grant_o), 32'(oh));
          chk("frame_ack", 32'(ack_o), 32'(oh));
        end
        held_data = tx_data_o;
      end else begin
        if (ack_o != '0) chk("ack_without_start", 32'(ack_o), 32'd0);
        if (grant_o != '0) chk("data_hold", 32'(tx_data_o), 32'(held_data));
      end
      if (!busy_o) chk("idle_no_grant", 32'(grant_o), 32'd0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [DW-1:0] lb1 [3];
  logic [DW-1:0] lb0, lb3;
  int            nwait;

  initial begin
    rst_n_i    = 1'b1;
    tx_auto    = 1'b1;
    force_busy = 1'b0;
    mdl_busy   = 1'b0;
    tx_pending = 1'b0;
    tx_wait    = 0;
    tx_left    = 0;
    tx_fixed   = 1'b1;
    lock_hold  = '0;
    for (int k = 0; k < N; k++) begin
      head[k] = 0;
      cnt[k]  = 0;
    end
    mdl_last = N - 1;
    drive_reqs();
    #2 rst_n_i = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_start", 32'(tx_start_o), 32'd0);
    chk("rst_data", 32'(tx_data_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);

    // Four requesters, requester 0 twice: 0x41,0x42,0x43,0x44,0x41.
    push_byte(0, 8'h41); push_byte(0, 8'h41);
    push_byte(1, 8'h42); push_byte(2, 8'h43); push_byte(3, 8'h44);
    model_plan();
    drive_reqs();
    rst_n_i = 1'b1;
    tick();
    chk("release_no_early_start", 32'(tx_start_o), 32'd0);
    drain("rr_basic");
    tx_fixed = 1'b0;

    // Single pulse from requester 2.
    push_byte(2, 8'h5A);
    model_plan();
    drive_reqs();
    tick();
    chk("single_start", 32'(tx_start_o), 32'd1);
    chk("single_ack", 32'(ack_o), 32'b0100);
    tick();
    chk("single_start_gone", 32'(tx_start_o), 32'd0);
    chk("single_ack_gone", 32'(ack_o), 32'd0);
    chk("single_grant_held", 32'(grant_o), 32'b0100);
    chk("single_data_held", 32'(tx_data_o), 32'h5A);
    drain("single");
    chk("single_grant_cleared", 32'(grant_o), 32'd0);

    // Transmitter held busy externally: nothing may start.
    tx_auto    = 1'b0;
    force_busy = 1'b1;
    push_byte(0, DW'($urandom));
    model_plan();
    drive_reqs();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_no_start_ack", {27'd0, tx_start_o, ack_o}, 32'd0);
    end
    force_busy = 1'b0;
    tx_auto    = 1'b1;
    tick();
    chk("busy_drop_grant", 32'(tx_start_o), 32'd1);
    drain("busy_hold");

    // Lock scenario; previous winner is requester 0.
    for (int i = 0; i < 3; i++) lb1[i] = DW'($urandom);
    lb0 = DW'($urandom);
    lb3 = DW'($urandom);
    for (int i = 0; i < 3; i++) push_byte(1, lb1[i]);
    push_byte(0, lb0);
    push_byte(3, lb3);
    lock_hold = 4'b0010;
`ifdef UART_ARB_LOCK_EN
    exp_q.push_back({3'd1, lb1[0]});
    exp_q.push_back({3'd1, lb1[1]});
    exp_q.push_back({3'd1, lb1[2]});
    exp_q.push_back({3'd3, lb3});
    exp_q.push_back({3'd0, lb0});
    mdl_last = 0;
`else
    model_plan();
`endif
    drive_reqs();
    drain("lock");
    lock_hold = '0;

    // Randomized phases.
    for (int p = 0; p < 14; p++) begin
      for (int k = 0; k < N; k++) begin
        int m;
        m = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 3);
        for (int b = 0; b < m; b++) push_byte(k, DW'($urandom));
      end
      model_plan();
      drive_reqs();
      drain("random");
    end

    // Reset in the middle of a frame (WAIT_DONE).
    tx_fixed = 1'b1;
    push_byte(1, DW'($urandom));
    model_plan();
    drive_reqs();
    nwait = 0;
    tick();
    while (!tx_start_o && nwait < 10) begin
      tick();
      nwait++;
    end
    chk("abort_start_seen", 32'(tx_start_o), 32'd1);
    tick();
    tick();
    chk("abort_busy_before_rst", 32'(busy_o), 32'd1);
    #2 rst_n_i = 1'b0;
    #1;
    chk("abort_rst_grant", 32'(grant_o), 32'd0);
    chk("abort_rst_start", 32'(tx_start_o), 32'd0);
    chk("abort_rst_ack", 32'(ack_o), 32'd0);
    chk("abort_rst_data", 32'(tx_data_o), 32'd0);
    chk("abort_rst_busy", 32'(busy_o), 32'd0);
    mdl_busy   = 1'b0;
    tx_pending = 1'b0;
    tx_fixed   = 1'b0;
    mdl_last   = N - 1;
    chk("abort_exp_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    rst_n_i = 1'b1;
    push_byte(3, DW'($urandom));
    model_plan();
    drive_reqs();
    tick();
    chk("abort_release_no_early", {27'd0, tx_start_o, ack_o}, 32'd0);
    tick();
    chk("abort_new_grant", 32'(grant_o), 32'b1000);
    chk("abort_new_ack", 32'(ack_o), 32'b1000);
    drain("after_abort");

    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < N; k++) begin
        int m;
        m = $urandom_range(0, 2);
        for (int b = 0; b < m; b++) push_byte(k, DW'($urandom));
      end
      model_plan();
      drive_reqs();
      drain("random_post");
    end

    chk("final_exp_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
